nnet_mul_share_arb: RTL

- Time-shares one pipelined multiplier of the 25-bit unsigned × 8-bit signed kind among N_REQ requesters in the quantized CNN datapath.
- Typical requesters are convolution/dense lanes whose multiply rate is below one per cycle each.
- A round-robin arbiter issues at most one operand pair per cycle into a NUM_STAGE-deep pipeline.
- Each product returns tagged with the requester id, over a valid/ready response port that can stall the whole pipeline.

---
 rtl/nnet_mul_share_arb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/nnet_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : nnet_mul_share_arb
// Brief    : Round-robin time-sharing of one pipelined 25u x 8s multiplier
//            among N_REQ requesters of the quantized CNN datapath. Products
//            return in accept order, tagged with the requester id, over a
//            valid/ready port whose back-pressure freezes the whole pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module nnet_mul_share_arb #(
    parameter int N_REQ     = 4,
    parameter int A_WIDTH   = 25,
    parameter int B_WIDTH   = 8,
    parameter int P_WIDTH   = 32,
    parameter int NUM_STAGE = 2,
    parameter int ID_W      = 2
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*A_WIDTH-1:0]   req_a,
    input  logic [N_REQ*B_WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [P_WIDTH-1:0]         rsp_p
);

    // Highest requester index; the pointer wraps to 0 after it.
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                 w_stall;
    logic                 w_found;
    logic                 w_accept;
    logic [N_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]      w_gnt_id;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W-1:0]      r_ptr;

    // The output register is the last pipeline stage, so a held response
    // freezes every stage and blocks new accepts.
    assign w_stall = rsp_valid & ~rsp_ready;

    // Search from the pointer upward (mod N_REQ) for the first valid requester.
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found      = 1'b1;
                w_gnt_id     = w_idx;
                w_gnt[w_idx] = 1'b1;
            end
        end
    end

    assign req_ready = w_stall ? '0 : w_gnt;
    assign w_accept  = w_found & ~w_stall;

    // Pointer moves just past the requester that was accepted.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand selection: AND-OR by grant so non-granted operands (even X)
    // never reach the multiplier.
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0] w_sel_a;
    logic [B_WIDTH-1:0] w_sel_b;

    // Route the granted requester's operands; zero when nobody is granted.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*A_WIDTH +: A_WIDTH];
                w_sel_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiplier core. Operands are sign-extended (a via a leading zero)
    // to the product width before multiplying; arithmetic mod 2^P_WIDTH
    // gives the two's-complement wrap directly, and also covers the case
    // where P_WIDTH is narrower than the full product.
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0]        w_mul_a;
    logic [B_WIDTH-1:0]        w_mul_b;
    logic signed [A_WIDTH:0]   w_a_s;
    logic signed [B_WIDTH-1:0] w_b_s;
    logic [P_WIDTH-1:0]        w_prod;

    assign w_a_s  = {1'b0, w_mul_a};
    assign w_b_s  = w_mul_b;
    assign w_prod = P_WIDTH'(w_a_s) * P_WIDTH'(w_b_s);

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    if (NUM_STAGE == 1) begin : g_one_stage
        logic               r_vld;
        logic [ID_W-1:0]    r_id;
        logic [P_WIDTH-1:0] r_p;

        assign w_mul_a = w_sel_a;
        assign w_mul_b = w_sel_b;

        // Single stage: multiply straight from the operand mux into the output.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                r_vld <= 1'b0;
                r_id  <= '0;
                r_p   <= '0;
            end else if (!w_stall) begin
                r_vld <= w_accept;
                r_id  <= w_gnt_id;
                r_p   <= w_prod;
            end
        end

        assign rsp_valid = r_vld;
        assign rsp_id    = r_id;
        assign rsp_p     = r_p;
    end else begin : g_multi_stage
        logic [A_WIDTH-1:0] r_a;
        logic [B_WIDTH-1:0] r_b;
        logic               r_vld [NUM_STAGE];
        logic [ID_W-1:0]    r_id  [NUM_STAGE];
        logic [P_WIDTH-1:0] r_p   [1:NUM_STAGE-1];

        assign w_mul_a = r_a;
        assign w_mul_b = r_b;

        // Stage 0 registers operands, stage 1 the product, later stages
        // only delay it; all stages advance together unless stalled.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                r_a <= '0;
                r_b <= '0;
                for (int s = 0; s < NUM_STAGE; s++) begin
                    r_vld[s] <= 1'b0;
                    r_id[s]  <= '0;
                end
                for (int s = 1; s < NUM_STAGE; s++) begin
                    r_p[s] <= '0;
                end
            end else if (!w_stall) begin
                r_vld[0] <= w_accept;
                r_id[0]  <= w_gnt_id;
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_vld[1] <= r_vld[0];
                r_id[1]  <= r_id[0];
                r_p[1]   <= w_prod;
                for (int s = 2; s < NUM_STAGE; s++) begin
                    r_vld[s] <= r_vld[s-1];
                    r_id[s]  <= r_id[s-1];
                    r_p[s]   <= r_p[s-1];
                end
            end
        end

        assign rsp_valid = r_vld[NUM_STAGE-1];
        assign rsp_id    = r_id[NUM_STAGE-1];
        assign rsp_p     = r_p[NUM_STAGE-1];
    end

endmodule
`default_nettype wire
